// File: rtl/ram_sp_ctrl.sv
// ram_sp_ctrl: initiator-side controller for a single-port synchronous RAM
// with a registered read port. Turns a valid/ready request stream into RAM
// access cycles and returns read data on a valid/ready response stream.
// Addresses at or above DEPTH are trapped: writes are dropped and reads
// return rsp_err=1 with zero data. err_sticky records any such request.
//
// Optional feature: define RAM_SP_CTRL_MEM_INIT_EN to add an INIT state that
// zero-fills the RAM (one word per cycle) after every reset before the
// controller starts accepting requests.
module ram_sp_ctrl #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 8,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_wr,
    input  logic [AW-1:0]    req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic             err_sticky,
    output logic             busy,
    output logic             ram_ce,
    output logic             ram_r_wn,
    output logic [AW-1:0]    ram_addr,
    output logic [WIDTH-1:0] ram_wdata,
    input  logic [WIDTH-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_RSP
`ifdef RAM_SP_CTRL_MEM_INIT_EN
        , ST_INIT
`endif
    } state_t;

`ifdef RAM_SP_CTRL_MEM_INIT_EN
    localparam state_t RESET_STATE = ST_INIT;
    logic [AW-1:0] init_addr;
`else
    localparam state_t RESET_STATE = ST_IDLE;
`endif

    state_t state;
    logic   accept;
    logic   in_range;

    // Gating with rst_n keeps req_ready (and through it ram_ce) low for the
    // whole reset pulse, so the RAM bus goes quiet asynchronously.
    assign req_ready = rst_n && (state == ST_IDLE);
    assign accept    = req_valid && req_ready;
    // DEPTH need not be a power of two, so the top codes of the address
    // space have no backing word.
    assign in_range  = ({1'b0, req_addr} < (AW + 1)'(DEPTH));
    assign busy      = (state != ST_IDLE);

    // RAM drive: follows the accepted request combinationally, idle bus otherwise.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        ram_ce    = 1'b0;
        ram_r_wn  = 1'b1;
        ram_addr  = '0;
        ram_wdata = '0;
        if (accept && in_range) begin
            ram_ce    = 1'b1;
            ram_r_wn  = !req_wr;
            ram_addr  = req_addr;
            ram_wdata = req_wdata;
        end
`ifdef RAM_SP_CTRL_MEM_INIT_EN
        if (rst_n && state == ST_INIT) begin
            ram_ce   = 1'b1;
            ram_r_wn = 1'b0;
            ram_addr = init_addr;
        end
`endif
    end

    // Control FSM with registered response outputs and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RESET_STATE;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            err_sticky <= 1'b0;
`ifdef RAM_SP_CTRL_MEM_INIT_EN
            init_addr  <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register updates from
            // pre-edge values regardless of statement order.
            if (accept && !in_range) begin
                err_sticky <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (accept && !req_wr) begin
                        if (in_range) begin
                            state <= ST_RD_WAIT;
                        end else begin
                            state     <= ST_RSP;
                            rsp_valid <= 1'b1;
                            rsp_data  <= '0;
                            rsp_err   <= 1'b1;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    // RAM read data is valid during this cycle; capture it.
                    state     <= ST_RSP;
                    rsp_valid <= 1'b1;
                    rsp_data  <= ram_rdata;
                    rsp_err   <= 1'b0;
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
`ifdef RAM_SP_CTRL_MEM_INIT_EN
                ST_INIT: begin
                    if (init_addr == AW'(DEPTH - 1)) begin
                        state     <= ST_IDLE;
                        init_addr <= '0;
                    end else begin
                        init_addr <= init_addr + 1'b1;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_sp_ctrl.sv
// tb_ram_sp_ctrl: self-checking bench for ram_sp_ctrl (DEPTH=3, WIDTH=8).
// A behavioural RAM sits on the RAM port; a transaction-level model predicts
// every DUT output each cycle. Directed scenarios pin latency, backpressure,
// out-of-range trapping and reset; a random phase follows.
module tb_ram_sp_ctrl;

    localparam int DEPTH = 3;
    localparam int WIDTH = 8;
    localparam int AW    = $clog2(DEPTH);
`ifdef RAM_SP_CTRL_MEM_INIT_EN
    localparam int INIT_CYCLES = DEPTH;
`else
    localparam int INIT_CYCLES = 0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid, req_ready, req_wr;
    logic [AW-1:0]    req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             rsp_valid, rsp_ready, rsp_err, err_sticky, busy;
    logic [WIDTH-1:0] rsp_data;
    logic             ram_ce, ram_r_wn;
    logic [AW-1:0]    ram_addr;
    logic [WIDTH-1:0] ram_wdata;
    logic [WIDTH-1:0] ram_rdata;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit rnd_mode = 0;
    int last_acc_cyc;
    logic [WIDTH:0] rsp_log[$];   // {err, data} per completed handshake

    ram_sp_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .err_sticky(err_sticky), .busy(busy),
        .ram_ce(ram_ce), .ram_r_wn(ram_r_wn), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural single-port RAM with registered read data.
    logic [WIDTH-1:0] tb_mem [4];
    initial begin
        for (int i = 0; i < 4; i++) tb_mem[i] = '0;
        ram_rdata = '0;
    end
    always @(posedge clk) begin
        if (ram_ce) begin
            if (!ram_r_wn) tb_mem[ram_addr] <= ram_wdata;
            else           ram_rdata <= tb_mem[ram_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference model: one outstanding read at most,
    // response visible 2 cycles after an in-range accept, 1 after an
    // out-of-range accept, held until the handshake.
    int             m_mem [DEPTH];
    bit             m_pending;
    int             m_delay;
    logic [WIDTH-1:0] m_data;
    bit             m_err;
    bit             m_sticky;
    int             m_init_left;
    initial for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;

    always @(posedge clk or negedge rst_n) begin
        bit m_busy, m_acc;
        if (!rst_n) begin
            m_pending   = 0;
            m_delay     = 0;
            m_sticky    = 0;
            m_init_left = INIT_CYCLES;
        end else begin
            m_busy = m_pending || (m_init_left > 0);
            m_acc  = req_valid && !m_busy;
            if (m_init_left > 0) begin
                m_mem[DEPTH - m_init_left] = 0;
                m_init_left--;
            end else if (m_pending) begin
                if (m_delay > 0) m_delay--;
                else if (rsp_ready) m_pending = 0;
            end else if (m_acc) begin
                if (int'(req_addr) >= DEPTH) begin
                    m_sticky = 1;
                    if (!req_wr) begin
                        m_pending = 1; m_delay = 0; m_data = '0; m_err = 1;
                    end
                end else if (req_wr) begin
                    m_mem[int'(req_addr)] = int'(req_wdata);
                end else begin
                    m_pending = 1; m_delay = 1;
                    m_data = WIDTH'(m_mem[int'(req_addr)]); m_err = 0;
                end
            end
        end
    end

    // Compare process: every output against the model, mid-cycle.
    always @(negedge clk) begin
        bit e_busy, e_ready, e_ce, e_valid, e_init;
        e_init  = (m_init_left > 0);
        e_busy  = m_pending || e_init;
        e_ready = rst_n && !e_busy;
        e_ce    = rst_n && (e_init || (req_valid && !e_busy && int'(req_addr) < DEPTH));
        e_valid = m_pending && (m_delay == 0);
        check("req_ready", 32'(req_ready), 32'(e_ready));
        check("busy", 32'(busy), 32'(e_busy));
        check("err_sticky", 32'(err_sticky), 32'(m_sticky));
        check("rsp_valid", 32'(rsp_valid), 32'(e_valid));
        check("ram_ce", 32'(ram_ce), 32'(e_ce));
        if (e_ce && e_init) begin
            check("init_r_wn", 32'(ram_r_wn), 32'd0);
            check("init_addr", 32'(ram_addr), 32'(DEPTH - m_init_left));
            check("init_wdata", 32'(ram_wdata), 32'd0);
        end else if (e_ce) begin
            check("ram_r_wn", 32'(ram_r_wn), 32'(!req_wr));
            check("ram_addr", 32'(ram_addr), 32'(req_addr));
            if (req_wr) check("ram_wdata", 32'(ram_wdata), 32'(req_wdata));
        end else begin
            check("idle_bus", {ram_r_wn, 7'd0, 8'(ram_addr), 8'd0, ram_wdata}, 32'h8000_0000);
        end
        if (e_valid) begin
            check("rsp_data", 32'(rsp_data), 32'(m_data));
            check("rsp_err", 32'(rsp_err), 32'(m_err));
            if (rsp_ready && rst_n) rsp_log.push_back({rsp_err, rsp_data});
        end
    end

    task automatic send(input logic wr, input int a, input logic [WIDTH-1:0] d);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        req_valid = 1'b1; req_wr = wr; req_addr = AW'(a); req_wdata = d;
        while (!acc) begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
            #1;
            if (rnd_mode) rsp_ready = ($urandom_range(3) != 0);
            if (!acc) begin
                n++;
                if (n > 60) begin
                    check("req_accept_timeout", 32'd0, 32'd1);
                    acc = 1'b1;
                end
            end
        end
        req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
        last_acc_cyc = cyc;
    endtask

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int c0, c1, c2, base;
        rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0;
        req_wdata = '0; rsp_ready = 1'b1;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp", {rsp_valid, rsp_err, err_sticky, ram_ce, 20'd0, rsp_data}, 32'd0);
        wait_neg(3);
        @(posedge clk); #2 rst_n = 1'b1;

`ifdef RAM_SP_CTRL_MEM_INIT_EN
        // First read after the zero-fill sweep returns 0.
        tb_mem[0] = 8'hFF;
        base = rsp_log.size();
        send(1'b0, 0, '0);
        wait_neg(3);
        check("init_read_zero", 32'(rsp_log[base]), 32'h000);
`endif

        // Write 0xA5 to addr 2, then read it back: response 2 cycles after accept.
        send(1'b1, 2, 8'hA5);
        send(1'b0, 2, '0);
        @(negedge clk);
        check("t1_rdwait_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("t1_valid", 32'(rsp_valid), 32'd1);
        check("t1_data", 32'(rsp_data), 32'hA5);
        check("t1_err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        check("t1_released", 32'(rsp_valid), 32'd0);

        // Back-to-back writes, then reads at 3 cycles each.
        @(posedge clk); #1;
        send(1'b1, 0, 8'h11); c0 = last_acc_cyc;
        send(1'b1, 1, 8'h22); c1 = last_acc_cyc;
        send(1'b1, 2, 8'h33); c2 = last_acc_cyc;
        check("wr_b2b_1", 32'(c1 - c0), 32'd1);
        check("wr_b2b_2", 32'(c2 - c1), 32'd1);
        base = rsp_log.size();
        send(1'b0, 0, '0); c0 = last_acc_cyc;
        send(1'b0, 1, '0); c1 = last_acc_cyc;
        send(1'b0, 2, '0); c2 = last_acc_cyc;
        check("rd_rate_1", 32'(c1 - c0), 32'd3);
        check("rd_rate_2", 32'(c2 - c1), 32'd3);
        wait_neg(3);
        check("rd_order_0", 32'(rsp_log[base]),     32'h011);
        check("rd_order_1", 32'(rsp_log[base + 1]), 32'h022);
        check("rd_order_2", 32'(rsp_log[base + 2]), 32'h033);

        // Backpressure: hold rsp_ready low for 5 cycles in RSP.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        send(1'b0, 1, '0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_data", 32'(rsp_data), 32'h22);
            check("bp_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release", 32'(rsp_valid), 32'd0);

        // Out-of-range write and read at addr 3.
        @(posedge clk); #1;
        send(1'b1, 3, 8'h77);
        @(negedge clk);
        check("oor_sticky_wr", 32'(err_sticky), 32'd1);
        @(posedge clk); #1;
        send(1'b0, 3, '0);
        @(negedge clk);
        check("oor_rsp", {rsp_valid, rsp_err, 22'd0, rsp_data}, {2'b11, 30'd0});
        send(1'b0, 2, '0);
        wait_neg(3);
        check("oor_no_write", 32'(rsp_log[rsp_log.size() - 1]), 32'h033);
        check("oor_sticky_hold", 32'(err_sticky), 32'd1);

        // Reset pulse while a read sits in RD_WAIT.
        @(posedge clk); #1;
        send(1'b0, 1, '0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_ce", 32'(ram_ce), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        check("mid_rst_sticky", 32'(err_sticky), 32'd0);
        wait_neg(2);
        @(posedge clk); #2 rst_n = 1'b1;
        base = rsp_log.size();
        send(1'b0, 0, '0);
        wait_neg(3);
        check("post_rst_count", 32'(rsp_log.size() - base), 32'd1);
`ifdef RAM_SP_CTRL_MEM_INIT_EN
        check("post_rst_read", 32'(rsp_log[base]), 32'h000);
`else
        check("post_rst_read", 32'(rsp_log[base]), 32'h011);
`endif

        // Random traffic with random response backpressure.
        @(posedge clk); #1;
        rnd_mode = 1;
        for (int i = 0; i < 400; i++) begin
            send(1'($urandom_range(1)), int'($urandom_range(3)), 8'($urandom));
        end
        rnd_mode = 0;
        rsp_ready = 1'b1;
        wait_neg(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
